// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus instruction-cache geometry helpers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, FILL} icache_state_t;

  // Tag bits left after dropping the byte offset, word offset and index fields.
  function automatic int unsigned icache_tag_width(input int unsigned sets,
                                                   input int unsigned block_words);
    return 32 - 2 - $clog2(sets) - $clog2(block_words);
  endfunction

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and block data, held in flops.
module icache_way
  import cpu_types_pkg::*;
#(
  parameter  int unsigned SETS        = 8,
  parameter  int unsigned BLOCK_WORDS = 2,
  parameter  int unsigned TAG_W       = 26,
  localparam int unsigned IW          = $clog2(SETS),
  localparam int unsigned WOE         = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IW-1:0]    rd_idx,
  input  logic [WOE-1:0]   rd_wo,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WOE-1:0]   wr_wo,
  input  logic             data_we,
  input  word_t            wdata,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wtag,
  input  logic             inv_one,
  input  logic             inv_all,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output word_t            data
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  word_t            data_q [SETS][BLOCK_WORDS];
  word_t            data_d [SETS][BLOCK_WORDS];

  // Invalidate-all is applied last so a flush beats a same-cycle tag write.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (data_we) data_d[wr_idx][wr_wo] = wdata;
    if (inv_one) valid_d[wr_idx] = 1'b0;
    if (tag_we) begin
      tag_d[wr_idx]   = wtag;
      valid_d[wr_idx] = 1'b1;
    end
    if (inv_all) valid_d = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign valid = valid_q[rd_idx];
  assign tag   = tag_q[rd_idx];
  assign data  = data_q[rd_idx][rd_wo];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU victim choice, block burst fill,
// single-cycle flush and saturating hit/miss counters.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned CPUID       = 0
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iflush,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned WOW = $clog2(BLOCK_WORDS);
  localparam int unsigned WOE = (WOW > 0) ? WOW : 1;
  localparam int unsigned TW  = icache_tag_width(SETS, BLOCK_WORDS);
  localparam word_t          WO_MASK   = word_t'((BLOCK_WORDS - 1) << 2);
  localparam logic [WOE-1:0] LAST_WORD = WOE'(BLOCK_WORDS - 1);

  icache_state_t  state_q, state_d;
  logic [WOE-1:0] cnt_q, cnt_d;
  logic [TW-1:0]  tag_l_q, tag_l_d;
  logic [IW-1:0]  idx_l_q, idx_l_d;
  logic           victim_q, victim_d;
  logic [SETS-1:0] lru_q, lru_d;
  word_t          hit_cnt_q, hit_cnt_d;
  word_t          miss_cnt_q, miss_cnt_d;

  logic [TW-1:0]  req_tag;
  logic [IW-1:0]  req_idx;
  logic [WOE-1:0] req_wo;
  logic [IW-1:0]  wr_idx;

  logic [WAYS-1:0] way_valid, way_match;
  logic [WAYS-1:0] data_we, tag_we, inv_one;
  logic [TW-1:0]   way_tag  [WAYS];
  word_t           way_data [WAYS];

  logic  hit, hit_way, victim_sel;
  word_t hit_data;

  assign req_tag = imemaddr[31 -: TW];
  assign req_idx = imemaddr[2+WOW +: IW];

  generate
    if (BLOCK_WORDS > 1) begin : g_wo
      assign req_wo = imemaddr[2 +: WOE];
    end else begin : g_no_wo
      assign req_wo = '0;
    end
  endgenerate

  // The miss cycle invalidates at the request index; fill writes use the latched one.
  assign wr_idx = (state_q == FILL) ? idx_l_q : req_idx;

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
        .SETS        (SETS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_W       (TW)
      ) u_way (
        .CLK     (CLK),
        .nRST    (nRST),
        .rd_idx  (req_idx),
        .rd_wo   (req_wo),
        .wr_idx  (wr_idx),
        .wr_wo   (cnt_q),
        .data_we (data_we[w]),
        .wdata   (iload),
        .tag_we  (tag_we[w]),
        .wtag    (tag_l_q),
        .inv_one (inv_one[w]),
        .inv_all (iflush),
        .valid   (way_valid[w]),
        .tag     (way_tag[w]),
        .data    (way_data[w])
      );
      assign way_match[w] = way_valid[w] && (way_tag[w] == req_tag);
    end
  endgenerate

  always_comb begin
    hit_way  = 1'b0;
    hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_match[w]) begin
        hit_way  = 1'(w);
        hit_data = way_data[w];
      end
    end
  end

  assign hit = (state_q == IDLE) && imemREN && (|way_match);

  // With two ways: way 0 if it is free, else way 1 if it is free, else LRU.
  always_comb begin
    victim_sel = 1'b0;
    if (WAYS > 1) begin
      if (&way_valid) victim_sel = lru_q[req_idx];
      else            victim_sel = way_valid[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_l_d    = tag_l_q;
    idx_l_d    = idx_l_q;
    victim_d   = victim_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    data_we    = '0;
    tag_we     = '0;
    inv_one    = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          lru_d[req_idx] = ~hit_way;
          hit_cnt_d      = sat_inc(hit_cnt_q);
        end else if (imemREN) begin
          tag_l_d    = req_tag;
          idx_l_d    = req_idx;
          victim_d   = victim_sel;
          cnt_d      = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = FILL;
          for (int unsigned w = 0; w < WAYS; w++) inv_one[w] = (victim_sel == 1'(w));
        end
      end
      FILL: begin
        if (!iwait) begin
          for (int unsigned w = 0; w < WAYS; w++) data_we[w] = (victim_q == 1'(w));
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            for (int unsigned w = 0; w < WAYS; w++) tag_we[w] = (victim_q == 1'(w));
            lru_d[idx_l_q] = ~victim_q;
            cnt_d          = '0;
            state_d        = IDLE;
          end
        end
      end
    endcase
    if (iflush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lru_d      = '0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tag_l_q    <= '0;
      idx_l_q    <= '0;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_l_q    <= tag_l_d;
      idx_l_q    <= idx_l_d;
      victim_q   <= victim_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    if (state_q == FILL) begin
      iaddr = (word_t'(tag_l_q) << (2 + WOW + IW)) | (word_t'(idx_l_q) << (2 + WOW));
      if (BLOCK_WORDS > 1) iaddr = iaddr | (word_t'(cnt_q) << 2);
    end else begin
      iaddr = imemaddr & ~WO_MASK;
    end
  end

  assign ihit       = hit;
  assign imemload   = hit ? hit_data : '0;
  assign iREN       = (state_q == FILL);
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
